// File: rtl/ml_layer_sched.sv
// ml_layer_sched: layer-level command sequencer for the PE-array control FSM.
// It walks one layer as weights -> (LD_IF, IF2PE x Y_DIM, EXEC, OF2BUF x Y_DIM,
// OF2SRAM) per tile. Each command is offered on a valid/ack handshake, and the
// sequencer watches for an ack timeout. Every output comes straight from a
// register, so there is no combinational path from any input to any output.
module ml_layer_sched #(
  parameter int Y_DIM   = 5,
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              cmd_ack,
  output logic [TILE_W-1:0] tile_idx,
  output logic [2:0]        row_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // The wait counter never holds more than TIMEOUT-1 before it trips.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       ROW_LAST = 3'(Y_DIM - 1);

  localparam logic [2:0] C_DEFAULT = 3'b001;
  localparam logic [2:0] C_LD_WT   = 3'b010;
  localparam logic [2:0] C_LD_IF   = 3'b011;
  localparam logic [2:0] C_IF2PE   = 3'b100;
  localparam logic [2:0] C_EXEC    = 3'b101;
  localparam logic [2:0] C_OF2BUF  = 3'b110;
  localparam logic [2:0] C_OF2SRAM = 3'b111;

  typedef enum logic [3:0] {
    IDLE,
    S_WT,
    S_LDIF,
    S_IF2PE,
    S_EXEC,
    S_OF2BUF,
    S_OF2SRAM,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [TILE_W-1:0] ntiles_q, ntiles_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [2:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        cmd_q;
  logic              vld_q;
  logic              done_q;
  logic              err_q;

  // Command code driven while sitting in a state. Any state that issues no
  // command drives DEFAULT.
  function automatic logic [2:0] cmd_of(input state_e s);
    logic [2:0] c;
    c = C_DEFAULT;
    case (s)
      S_WT:      c = C_LD_WT;
      S_LDIF:    c = C_LD_IF;
      S_IF2PE:   c = C_IF2PE;
      S_EXEC:    c = C_EXEC;
      S_OF2BUF:  c = C_OF2BUF;
      S_OF2SRAM: c = C_OF2SRAM;
      default:   c = C_DEFAULT;
    endcase
    return c;
  endfunction

  // True in the states that offer a command on the handshake.
  function automatic logic is_cmd(input state_e s);
    return (s != IDLE) && (s != S_DONE) && (s != S_ERR);
  endfunction

  // Next-state, index and timeout-counter logic. Abort has priority over everything.
  always_comb begin
    state_d  = state_q;
    ntiles_d = ntiles_q;
    tile_d   = tile_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    if (abort) begin
      state_d = IDLE;
      tile_d  = '0;
      row_d   = '0;
      cnt_d   = '0;
    end else if (!is_cmd(state_q)) begin
      // Idle-like states: only start matters here, and ack is ignored.
      if (start) begin
        state_d  = S_WT;
        ntiles_d = cfg_num_tiles;
        tile_d   = '0;
        row_d    = '0;
        cnt_d    = '0;
      end else if (state_q == S_DONE) begin
        state_d = IDLE;
        tile_d  = '0;
        row_d   = '0;
      end
    end else if (cmd_ack) begin
      // Every accepted command restarts the wait counter.
      cnt_d = '0;
      case (state_q)
        S_WT:      state_d = (ntiles_q == '0) ? S_DONE : S_LDIF;
        S_LDIF:    state_d = S_IF2PE;
        S_IF2PE: begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_EXEC;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
        S_EXEC:    state_d = S_OF2BUF;
        S_OF2BUF: begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_OF2SRAM;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
        S_OF2SRAM: begin
          if (tile_q == ntiles_q - 1'b1) begin
            state_d = S_DONE;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = S_LDIF;
          end
        end
        default:   state_d = state_q;
      endcase
    end else if (cnt_q == CNT_LAST) begin
      // The wait is about to reach TIMEOUT, so the command is dropped.
      state_d = S_ERR;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register. Outputs are registered as a function of the next state,
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ntiles_q <= '0;
      tile_q   <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
      cmd_q    <= C_DEFAULT;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ntiles_q <= ntiles_d;
      tile_q   <= tile_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_of(state_d);
      vld_q    <= is_cmd(state_d);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = vld_q;
  // The busy states are exactly the states that issue a command.
  assign busy      = vld_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tile_idx  = tile_q;
  assign row_idx   = row_q;

endmodule
